// File: rtl/rca_bist.sv
// rtl/rca_bist.sv - exhaustive self-test sweep for a WIDTH-bit ripple-carry adder
// Optional first-failing-vector capture: define RCA_BIST_FIRST_FAIL_EN.
module rca_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic               c,
    input  logic [WIDTH-1:0]   s,
    input  logic               co,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        err_cnt,
    output logic [2*WIDTH:0]   fail_vec
);

    localparam int VW = 2 * WIDTH + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRIVE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

    logic [2:0]    state;
    logic [VW-1:0] vec;
    logic [3:0]    settle_cnt;
    logic [WIDTH:0] golden;
    logic          mismatch;
    logic [15:0]   err_nxt;
    logic          launch;

    // Golden sum is one bit wider than the operands so carry-out is checked too.
    assign golden   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    assign mismatch = ({co, s} != golden);
    assign err_nxt  = (mismatch && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;
    assign launch   = start && ((state == ST_IDLE) || (state == ST_DONE));

    assign busy = (state == ST_DRIVE) || (state == ST_WAIT) || (state == ST_CHECK);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            a          <= '0;
            b          <= '0;
            c          <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            vec        <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        state   <= ST_DRIVE;
                        err_cnt <= '0;
                        vec     <= '0;
                        pass    <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    {a, b, c}  <= vec;
                    settle_cnt <= SETTLE_INIT;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1)
                        state <= ST_CHECK;
                end
                ST_CHECK: begin
                    err_cnt <= err_nxt;
                    if (&vec) begin
                        state <= ST_DONE;
                        pass  <= (err_nxt == 16'd0);
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= ST_DRIVE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RCA_BIST_FIRST_FAIL_EN
    // err_cnt is still zero on the first mismatch of a sweep, so it marks "first".
    always_ff @(posedge clk) begin
        if (!rst_n)
            fail_vec <= '0;
        else if (launch)
            fail_vec <= '0;
        else if ((state == ST_CHECK) && mismatch && (err_cnt == 16'd0))
            fail_vec <= {a, b, c};
    end
`else
    assign fail_vec = '0;
`endif

endmodule

// File: tb/tb_rca_bist.sv
// tb/tb_rca_bist.sv - directed bench for rca_bist with good, faulty and pipelined adder models
module tb_rca_bist;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [1:0] mode = 2'd0;

    logic [3:0] a0, b0, s0, a1, b1, s1;
    logic       c0, co0, c1, co1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] err0, err1;
    logic [8:0]  fv0, fv1;

    logic [4:0] sum0, p1_0, p2_0, p1_1, p2_1;

    int n_vec = 0;
    int n_err = 0;
    int cyc;

`ifdef RCA_BIST_FIRST_FAIL_EN
    localparam logic [8:0] EXP_FV_CO = 9'h01F;
`else
    localparam logic [8:0] EXP_FV_CO = 9'h000;
`endif

    always #5 clk = ~clk;

    rca_bist #(.WIDTH(4), .SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .a(a0), .b(b0), .c(c0), .s(s0), .co(co0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .fail_vec(fv0)
    );

    rca_bist #(.WIDTH(4), .SETTLE(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .c(c1), .s(s1), .co(co1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_vec(fv1)
    );

    // Adder models: 0 good, 1 co stuck-at-0, 2 s[0] inverted, 3 two-cycle pipeline.
    assign sum0 = {1'b0, a0} + {1'b0, b0} + {4'b0, c0};

    always @(posedge clk) begin
        p1_0 <= sum0;
        p2_0 <= p1_0;
        p1_1 <= {1'b0, a1} + {1'b0, b1} + {4'b0, c1};
        p2_1 <= p1_1;
    end

    always_comb begin
        {co0, s0} = sum0;
        case (mode)
            2'd1: co0 = 1'b0;
            2'd2: s0  = sum0[3:0] ^ 4'b0001;
            2'd3: {co0, s0} = p2_0;
            default: ;
        endcase
    end

    assign {co1, s1} = p2_1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start on one DUT and count edges until done; optional stray starts at 10 and 50.
    task automatic sweep(input bit which, input bit stray, output int n);
        n = 0;
        @(negedge clk);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        while (n < 4000) begin
            @(posedge clk);
            #1;
            n++;
            start0 = 1'b0;
            if (stray && (n == 10 || n == 50))
                start0 = 1'b1;
            if (which ? done1 : done0)
                break;
        end
        start0 = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_pass", pass0, 1'b0);
        check("rst_err", err0, 16'd0);
        check("rst_abc", {a0, b0, c0}, 9'h000);
        check("rst_fv", fv0, 9'h000);
        rst_n = 1'b1;

        mode = 2'd0;
        sweep(1'b0, 1'b0, cyc);
        check("good_cycles", cyc, 1536);
        check("good_pass", pass0, 1'b1);
        check("good_err", err0, 16'd0);
        check("good_fv", fv0, 9'h000);
        check("good_busy", busy0, 1'b0);
        check("good_last_abc", {a0, b0, c0}, 9'h1FF);

        mode = 2'd1;
        sweep(1'b0, 1'b0, cyc);
        check("co0_cycles", cyc, 1536);
        check("co0_err", err0, 16'd256);
        check("co0_pass", pass0, 1'b0);
        check("co0_fv", fv0, EXP_FV_CO);

        mode = 2'd2;
        sweep(1'b0, 1'b0, cyc);
        check("s0inv_err", err0, 16'd512);
        check("s0inv_pass", pass0, 1'b0);
        check("s0inv_fv", fv0, 9'h000);

        // Abort a faulty sweep at cycle 200, then a clean sweep from IDLE.
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (199) @(posedge clk);
        #1;
        check("mid_err_nonzero", (err0 != 16'd0), 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_busy", busy0, 1'b0);
        check("abort_done", done0, 1'b0);
        check("abort_abc", {a0, b0, c0}, 9'h000);
        check("abort_err", err0, 16'd0);
        mode = 2'd0;
        sweep(1'b0, 1'b0, cyc);
        check("after_abort_cycles", cyc, 1536);
        check("after_abort_pass", pass0, 1'b1);
        check("after_abort_err", err0, 16'd0);

        // Starts while busy are ignored; start in DONE restarts and clears.
        mode = 2'd1;
        sweep(1'b0, 1'b1, cyc);
        check("stray_cycles", cyc, 1536);
        check("stray_err", err0, 16'd256);
        mode = 2'd0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        check("restart_busy", busy0, 1'b1);
        check("restart_err_clr", err0, 16'd0);
        check("restart_pass_clr", pass0, 1'b0);
        cyc = 0;
        while (!done0 && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("restart_cycles", cyc, 1536);
        check("restart_pass", pass0, 1'b1);

        // Pipelined adder: too short a settle fails, SETTLE=3 passes.
        mode = 2'd3;
        sweep(1'b0, 1'b0, cyc);
        check("pipe_s1_pass", pass0, 1'b0);
        check("pipe_s1_err_nz", (err0 != 16'd0), 1'b1);
        sweep(1'b1, 1'b0, cyc);
        check("pipe_s3_cycles", cyc, 2560);
        check("pipe_s3_pass", pass1, 1'b1);
        check("pipe_s3_err", err1, 16'd0);
        check("pipe_s3_fv", fv1, 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
